// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter:
// owner and read/write encodings, plus the response tag layout.
package mem_port_arbiter_pkg;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic RW_RD = 1'b1;
  localparam logic RW_WR = 1'b0;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/mem_port_arbiter_rsp_tag_pipe.sv
// DEPTH-stage shift register of {valid, owner} tags that follows each read
// through the memory latency so its data is returned to the right issuer.
module rsp_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rstn,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and data requesters.
// Optional fetch starvation guard is compiled in with `define ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 30,
  parameter int unsigned DW       = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_STALL,
  output logic          I_VALID,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_STALL,
  output logic          D_VALID,
  output logic [DW-1:0] D_RDATA,
  output logic          M_REQ,
  output logic          M_RW,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA
);

  if (RD_LAT < 1 || RD_LAT > 4 || MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_cfg
    $error("mem_port_arbiter: RD_LAT must be 1..4 and MAX_WAIT 1..15");
  end

  logic w_grant_i;
  logic w_grant_d;
  logic w_force_i;
  tag_t w_push;
  tag_t w_pop;

`ifdef ARB_FAIRNESS_EN
  logic [3:0] r_wait;

  assign w_force_i = (r_wait == 4'(MAX_WAIT));

  // Counts only cycles where fetch is actually waiting; any grant or idle clears it.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_wait <= '0;
    end else if (!I_REQ || w_grant_i) begin
      r_wait <= '0;
    end else if (r_wait != 4'(MAX_WAIT)) begin
      r_wait <= r_wait + 4'd1;
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  assign w_grant_d = D_REQ & ~(I_REQ & w_force_i);
  assign w_grant_i = I_REQ & ~w_grant_d;

  assign I_STALL = I_REQ & ~w_grant_i;
  assign D_STALL = D_REQ & ~w_grant_d;

  assign M_REQ   = I_REQ | D_REQ;
  assign M_RW    = w_grant_d ? D_RW : RW_RD;
  assign M_ADDR  = w_grant_d ? D_ADDR : (w_grant_i ? I_ADDR : '0);
  assign M_WDATA = w_grant_d ? D_WDATA : '0;

  assign w_push.valid = M_REQ & M_RW;
  assign w_push.owner = w_grant_d ? OWN_D : OWN_I;

  rsp_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk   (CLK),
    .rstn  (RSTN),
    .i_tag (w_push),
    .o_tag (w_pop)
  );

  // Gated by RSTN so nothing is returned while reset is asserted.
  assign I_VALID = RSTN & w_pop.valid & (w_pop.owner == OWN_I);
  assign D_VALID = RSTN & w_pop.valid & (w_pop.owner == OWN_D);
  assign I_RDATA = I_VALID ? M_RDATA : '0;
  assign D_RDATA = D_VALID ? M_RDATA : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// sharing stimulus. Fairness expectations follow `ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          D_REQ;
  logic          D_RW;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic [DW-1:0] M_RDATA;

  logic          a_i_stall, a_i_valid, a_d_stall, a_d_valid, a_m_req, a_m_rw;
  logic [DW-1:0] a_i_rdata, a_d_rdata, a_m_wdata;
  logic [AW-1:0] a_m_addr;
  logic          b_i_stall, b_i_valid, b_d_stall, b_d_valid, b_m_req, b_m_rw;
  logic [DW-1:0] b_i_rdata, b_d_rdata, b_m_wdata;
  logic [AW-1:0] b_m_addr;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_WAIT(3)) u_dut1 (
    .CLK(CLK), .RSTN(RSTN),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_STALL(a_i_stall), .I_VALID(a_i_valid), .I_RDATA(a_i_rdata),
    .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_STALL(a_d_stall), .D_VALID(a_d_valid), .D_RDATA(a_d_rdata),
    .M_REQ(a_m_req), .M_RW(a_m_rw), .M_ADDR(a_m_addr), .M_WDATA(a_m_wdata), .M_RDATA(M_RDATA)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_WAIT(3)) u_dut3 (
    .CLK(CLK), .RSTN(RSTN),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_STALL(b_i_stall), .I_VALID(b_i_valid), .I_RDATA(b_i_rdata),
    .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_STALL(b_d_stall), .D_VALID(b_d_valid), .D_RDATA(b_d_rdata),
    .M_REQ(b_m_req), .M_RW(b_m_rw), .M_ADDR(b_m_addr), .M_WDATA(b_m_wdata), .M_RDATA(M_RDATA)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin : stim
    logic fair;
    logic exp_fetch;
`ifdef ARB_FAIRNESS_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    RSTN = 1'b0; I_REQ = 1'b0; I_ADDR = '0; D_REQ = 1'b0; D_RW = 1'b1;
    D_ADDR = '0; D_WDATA = '0; M_RDATA = '0;
    step(); step();
    settle();
    chk("rst_i_valid", a_i_valid, 0);
    chk("rst_d_valid", a_d_valid, 0);
    chk("rst_m_req",   a_m_req,   0);
    chk("rst_m_addr",  a_m_addr,  0);
    chk("rst_stalls",  {a_i_stall, a_d_stall}, 0);
    RSTN = 1'b1;
    step();

    // fetch only
    I_REQ = 1'b1; I_ADDR = 30'h10;
    settle();
    chk("f_i_stall", a_i_stall, 0);
    chk("f_m_addr",  a_m_addr,  30'h10);
    chk("f_m_rw",    a_m_rw,    1);
    step();
    I_REQ = 1'b0; M_RDATA = 32'hDEADBEEF;
    settle();
    chk("f_i_valid", a_i_valid, 1);
    chk("f_i_rdata", a_i_rdata, 32'hDEADBEEF);
    chk("f_d_valid", a_d_valid, 0);
    step();
    M_RDATA = '0;
    settle();
    chk("f_i_valid_off", a_i_valid, 0);

    // contention, data read wins
    I_REQ = 1'b1; I_ADDR = 30'h44; D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 30'h20;
    settle();
    chk("c_m_addr",  a_m_addr,  30'h20);
    chk("c_i_stall", a_i_stall, 1);
    chk("c_d_stall", a_d_stall, 0);
    step();
    D_REQ = 1'b0; M_RDATA = 32'hCAFEF00D;
    settle();
    chk("c_d_valid", a_d_valid, 1);
    chk("c_d_rdata", a_d_rdata, 32'hCAFEF00D);
    chk("c_i_valid", a_i_valid, 0);
    chk("c_i_grant", a_i_stall, 0);
    chk("c_m_addr2", a_m_addr,  30'h44);
    step();
    I_REQ = 1'b0; M_RDATA = 32'h0BADF00D;
    settle();
    chk("c_i_valid2", a_i_valid, 1);
    chk("c_i_rdata2", a_i_rdata, 32'h0BADF00D);
    chk("c_d_valid2", a_d_valid, 0);
    step();

    // data write against fetch
    I_REQ = 1'b1; I_ADDR = 30'h50; D_REQ = 1'b1; D_RW = 1'b0; D_ADDR = 30'h30;
    D_WDATA = 32'h12345678; M_RDATA = '0;
    settle();
    chk("w_m_rw",    a_m_rw,    0);
    chk("w_m_wdata", a_m_wdata, 32'h12345678);
    chk("w_m_addr",  a_m_addr,  30'h30);
    chk("w_i_stall", a_i_stall, 1);
    step();
    D_REQ = 1'b0; M_RDATA = 32'hFFFFFFFF;
    settle();
    chk("w_no_valid", {a_i_valid, a_d_valid}, 0);
    chk("w_i_grant",  a_i_stall, 0);
    chk("w_m_addr2",  a_m_addr,  30'h50);
    chk("w_m_wdata0", a_m_wdata, 0);
    step();
    I_REQ = 1'b0;
    settle();
    chk("w_i_valid", a_i_valid, 1);
    chk("w_i_rdata", a_i_rdata, 32'hFFFFFFFF);
    step();

    // sustained contention: D,D,D,I with fairness, else always D
    I_REQ = 1'b1; I_ADDR = 30'h60; D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 30'h61; M_RDATA = '0;
    for (int i = 0; i < 8; i++) begin
      exp_fetch = fair && ((i % 4) == 3);
      settle();
      chk($sformatf("fair_i_stall_%0d", i), a_i_stall, !exp_fetch);
      chk($sformatf("fair_d_stall_%0d", i), a_d_stall, exp_fetch);
      step();
    end
    I_REQ = 1'b0; D_REQ = 1'b0;
    step(); step(); step(); step();

    // RD_LAT=3, alternating owners
    I_REQ = 1'b1; I_ADDR = 30'h100;
    step();
    I_REQ = 1'b0; D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 30'h200;
    step();
    D_REQ = 1'b0; I_REQ = 1'b1; I_ADDR = 30'h101;
    step();
    I_REQ = 1'b0; M_RDATA = 32'hA1A1A1A1;
    settle();
    chk("l3_i_valid0", b_i_valid, 1);
    chk("l3_i_rdata0", b_i_rdata, 32'hA1A1A1A1);
    chk("l3_d_valid0", b_d_valid, 0);
    step();
    M_RDATA = 32'hA2A2A2A2;
    settle();
    chk("l3_d_valid1", b_d_valid, 1);
    chk("l3_d_rdata1", b_d_rdata, 32'hA2A2A2A2);
    chk("l3_i_valid1", b_i_valid, 0);
    step();
    M_RDATA = 32'hA3A3A3A3;
    settle();
    chk("l3_i_valid2", b_i_valid, 1);
    chk("l3_i_rdata2", b_i_rdata, 32'hA3A3A3A3);
    step();
    M_RDATA = '0;
    settle();
    chk("l3_idle", {b_i_valid, b_d_valid}, 0);

    // build up wait count, then reset with reads in flight
    I_REQ = 1'b1; I_ADDR = 30'h70; D_REQ = 1'b1; D_RW = 1'b1;
    step(); step();
    D_REQ = 1'b0;
    settle();
    chk("r_i_grant", a_i_stall, 0);
    RSTN = 1'b0; I_REQ = 1'b0;
    step();
    RSTN = 1'b1; M_RDATA = 32'h55555555;
    settle();
    chk("r_a_no_valid", {a_i_valid, a_d_valid}, 0);
    chk("r_a_i_rdata",  a_i_rdata, 0);
    step();
    settle();
    chk("r_b_no_valid1", {b_i_valid, b_d_valid}, 0);
    step();
    settle();
    chk("r_b_no_valid2", {b_i_valid, b_d_valid}, 0);
    M_RDATA = '0;

    // wait counter restarts from zero after reset
    I_REQ = 1'b1; D_REQ = 1'b1; D_RW = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_fetch = fair && (i == 3);
      settle();
      chk($sformatf("r_fair_i_stall_%0d", i), a_i_stall, !exp_fetch);
      step();
    end
    I_REQ = 1'b0; D_REQ = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the RISC_TOY fetch stage and memory stage. Each cycle it grants exactly one requester, stalls the loser, and tracks in-flight reads through a tag pipeline so each read returns to its issuer after the fixed memory latency. An optional starvation guard bounds how long fetch can be blocked by back-to-back data accesses. It sits between the core's IREQ/IADDR/INSTR and DREQ/DRW/DADDR/DWDATA/DRDATA ports and the single external memory port.

## Interface
- AW, 30, word-address width
- DW, 32, data width
- RD_LAT, 1, memory read latency in cycles (legal 1–4)
- MAX_WAIT, 3, consecutive denied fetch cycles before fetch is forced to win (legal 1–15)
- CLK  in  1  clock, all state on rising edge
- RSTN  in  1  reset, synchronous, active-low
- I_REQ  in  1  fetch request (always a read)
- I_ADDR  in  AW  fetch word address
- I_STALL  out  1  fetch request denied this cycle
- I_VALID  out  1  fetch read data valid
- I_RDATA  out  DW  fetch read data
- D_REQ  in  1  data request
- D_RW  in  1  1 = read, 0 = write
- D_ADDR  in  AW  data word address
- D_WDATA  in  DW  write data
- D_STALL  out  1  data request denied this cycle
- D_VALID  out  1  data read data valid (never for writes)
- D_RDATA  out  DW  data read data
- M_REQ  out  1  memory access strobe
- M_RW  out  1  1 = read, 0 = write
- M_ADDR  out  AW  memory address
- M_WDATA  out  DW  memory write data
- M_RDATA  in  DW  memory read data, valid RD_LAT cycles after a read strobe

## Operation
- Grant (combinational from requests and wait counter): one requester only → it wins. Both requesting → data wins, unless fairness is compiled in and wait_q == MAX_WAIT, in which case fetch wins.
- Loser's STALL = 1 in the same cycle; a requester with no request or that wins sees STALL = 0.
- Requester holds REQ/ADDR/RW/WDATA stable while stalled; the arbiter stores no request payload.
- M_* driven from the winner; M_REQ = I_REQ | D_REQ; M_RW = 1 for fetch grants; M_WDATA = D_WDATA on data grants, 0 otherwise; M_ADDR = 0 when idle.
- Tag pipeline: RD_LAT-deep shift register of {valid, owner}; pushes valid = M_REQ & M_RW, owner = winner each cycle. At the output stage: valid & owner = fetch → I_VALID = 1; owner = data → D_VALID = 1. I_RDATA/D_RDATA = M_RDATA while their VALID is 1, else 0.
- Wait counter wait_q (4 bits): increments when I_REQ & I_STALL, saturates at MAX_WAIT, clears to 0 on any cycle fetch is granted or I_REQ = 0.
- Writes occupy the port for one cycle and push an invalid tag.

## Timing
- Reset (RSTN = 0 at an edge): tag pipeline cleared, wait_q = 0. Responses for reads issued before reset are dropped (VALID stays 0). During reset, STALL/M_* follow the combinational grant; VALID/RDATA = 0.
- Grant and stall: 0-cycle latency. Read response: exactly RD_LAT cycles after grant.
- Throughput: one access per cycle; back-to-back reads from alternating owners return in issue order with no bubbles.
- Simultaneous data write and fetch: write wins, fetch stalled, fetch granted next cycle if D_REQ drops.
- Counter saturation: at MAX_WAIT, forced fetch grant stalls data for exactly one cycle, then wait_q = 0.

## Configuration
- ARB_FAIRNESS_EN defined: wait counter and forced-fetch rule present as above.
- Undefined: wait counter removed; data always wins contention; fetch may be stalled indefinitely.

## Structure
- Shared package: owner localparams OWN_I = 1'b0, OWN_D = 1'b1; RW encodings RW_RD = 1'b1, RW_WR = 1'b0.
- One sub-module: rsp_tag_pipe (RD_LAT-deep {valid, owner} shift register, sync active-low clear).

## Test plan
- Fetch only, I_ADDR = 0x10, RD_LAT = 1, M_RDATA = 0xDEADBEEF next cycle → I_STALL = 0, I_VALID = 1 with I_RDATA = 0xDEADBEEF one cycle later, D_VALID = 0.
- Both requesting, D_RW = 1, D_ADDR = 0x20 → M_ADDR = 0x20, I_STALL = 1, D_VALID = 1 after RD_LAT; fetch granted the cycle after D_REQ drops.
- Data write D_WDATA = 0x12345678 → M_RW = 0, M_WDATA = 0x12345678, no VALID pulse on either side.
- ARB_FAIRNESS_EN, MAX_WAIT = 3, both requesting continuously → data granted 3 cycles, fetch granted cycle 4, then data again (pattern D,D,D,I repeats).
- RD_LAT = 3, alternating I/D reads on consecutive cycles → VALIDs alternate I,D,I three cycles later, each with matching M_RDATA.
- Read granted, RSTN = 0 next edge → no VALID pulse for that read; all counters 0 after reset.
